// File: rtl/control_flow_sequencer.sv
// Issue-stage controller for j/bne/jal/jr/blt/bex/setx: decodes, waits on the ALU
// compare for branches, then emits a registered PC redirect / link write and a flush window.
module control_flow_sequencer #(
    parameter int ADDR_W       = 12,
    parameter int FLUSH_CYCLES = 2,
    parameter int CMP_TIMEOUT  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        opcode,
    input  logic [ADDR_W-1:0] pc,
    input  logic [26:0]       target,
    input  logic [16:0]       imm,
    input  logic [31:0]       rd_val,
    input  logic [31:0]       rstatus,
    output logic              cmp_req,
    input  logic              cmp_valid,
    input  logic              cmp_ne,
    input  logic              cmp_lt,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              link_we,
    output logic [4:0]        link_addr,
    output logic [31:0]       link_data,
    output logic              cmp_timeout
);

    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam int CNT_MAX = (CMP_TIMEOUT > FLUSH_CYCLES) ? CMP_TIMEOUT : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CMP = 2'd1,
        ST_EXEC     = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                is_blt_r, is_blt_s;
    logic [ADDR_W-1:0]   pc_r, pc_cap_s;
    logic [16:0]         imm_r, imm_cap_s;
    logic                ready_r;
    logic                cmp_req_r;
    logic                flush_r;
    logic                redirect_r, redirect_s;
    logic [ADDR_W-1:0]   target_r, target_s;
    logic                link_we_r, link_we_s;
    logic [4:0]          link_addr_r, link_addr_s;
    logic [31:0]         link_data_r, link_data_s;
    logic                timeout_s;
    logic                accept_s;
    logic                taken_s;
    logic [31:0]         imm_ext_s;
    logic [ADDR_W-1:0]   br_target_s;
    logic [ADDR_W-1:0]   pc_p1_s;
    logic                unused_s;

    assign accept_s    = instr_valid & ready_r;
    assign imm_ext_s   = {{15{imm_r[16]}}, imm_r};
    // Branch target wraps modulo 2^ADDR_W, so only the low bits of sext(imm) matter.
    assign br_target_s = pc_r + ADDR_W'(1) + imm_ext_s[ADDR_W-1:0];
    assign pc_p1_s     = pc + ADDR_W'(1);
    assign taken_s     = is_blt_r ? cmp_lt : cmp_ne;
    assign unused_s    = &{1'b0, rd_val[31:ADDR_W], imm_ext_s[31:ADDR_W]};

    // Next-state, counter and next-output decode
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        is_blt_s    = is_blt_r;
        pc_cap_s    = pc_r;
        imm_cap_s   = imm_r;
        redirect_s  = 1'b0;
        target_s    = target_r;
        link_we_s   = 1'b0;
        link_addr_s = link_addr_r;
        link_data_s = link_data_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    pc_cap_s  = pc;
                    imm_cap_s = imm;
                    is_blt_s  = (opcode == OP_BLT);
                    cnt_s     = '0;
                    case (opcode)
                        OP_BNE, OP_BLT: begin
                            state_s = ST_WAIT_CMP;
                        end
                        OP_J: begin
                            state_s    = ST_EXEC;
                            redirect_s = 1'b1;
                            target_s   = target[ADDR_W-1:0];
                        end
                        OP_JAL: begin
                            state_s     = ST_EXEC;
                            redirect_s  = 1'b1;
                            target_s    = target[ADDR_W-1:0];
                            link_we_s   = 1'b1;
                            link_addr_s = 5'd31;
                            link_data_s = {{(32-ADDR_W){1'b0}}, pc_p1_s};
                        end
                        OP_JR: begin
                            state_s    = ST_EXEC;
                            redirect_s = 1'b1;
                            target_s   = rd_val[ADDR_W-1:0];
                        end
                        OP_BEX: begin
                            state_s = ST_EXEC;
                            if (rstatus != 32'd0) begin
                                redirect_s = 1'b1;
                                target_s   = target[ADDR_W-1:0];
                            end else begin
                                redirect_s = 1'b0;
                            end
                        end
                        OP_SETX: begin
                            state_s     = ST_EXEC;
                            link_we_s   = 1'b1;
                            link_addr_s = 5'd30;
                            link_data_s = {5'b00000, target};
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_CMP: begin
                if (cmp_valid) begin
                    state_s = ST_EXEC;
                    if (taken_s) begin
                        redirect_s = 1'b1;
                        target_s   = br_target_s;
                    end else begin
                        redirect_s = 1'b0;
                    end
                end else if (cnt_r == CNT_W'(CMP_TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (redirect_r && (FLUSH_CYCLES > 0)) begin
                    state_s = ST_FLUSH;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured operands and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            is_blt_r    <= 1'b0;
            pc_r        <= '0;
            imm_r       <= 17'd0;
            ready_r     <= 1'b0;
            cmp_req_r   <= 1'b0;
            flush_r     <= 1'b0;
            redirect_r  <= 1'b0;
            target_r    <= '0;
            link_we_r   <= 1'b0;
            link_addr_r <= 5'd0;
            link_data_r <= 32'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            is_blt_r    <= is_blt_s;
            pc_r        <= pc_cap_s;
            imm_r       <= imm_cap_s;
            ready_r     <= (state_s == ST_IDLE);
            cmp_req_r   <= (state_s == ST_WAIT_CMP);
            flush_r     <= (state_s == ST_FLUSH);
            redirect_r  <= redirect_s;
            target_r    <= target_s;
            link_we_r   <= link_we_s;
            link_addr_r <= link_addr_s;
            link_data_r <= link_data_s;
        end
    end

    // Timeout must flag the same cycle cmp_valid fails to show, so it is decoded from state.
    assign cmp_timeout = timeout_s;
    assign instr_ready = ready_r;
    assign cmp_req     = cmp_req_r;
    assign flush       = flush_r;
    assign pc_redirect = redirect_r;
    assign pc_target   = target_r;
    assign link_we     = link_we_r;
    assign link_addr   = link_addr_r;
    assign link_data   = link_data_r;

endmodule
